// File: rtl/narrow_pkg.sv
// Shared constants and helpers for the narrowing pipeline: rounding mode encodings
// and the saturation bounds for a given output width and signedness.
package narrow_pkg;

  localparam logic [1:0] MODE_TRUNC   = 2'd0;
  localparam logic [1:0] MODE_HALF_UP = 2'd1;
  localparam logic [1:0] MODE_CONV    = 2'd2;
  localparam logic [1:0] MODE_CEIL    = 2'd3;

  typedef struct packed {
    logic signed [63:0] hi;
    logic signed [63:0] lo;
  } sat_bounds_t;

  // Clamp limits of an osize-bit result, wide enough for any legal lane width.
  function automatic sat_bounds_t sat_bounds(input int unsigned osize, input bit sgn);
    sat_bounds_t b;
    if (sgn) begin
      b.hi = (64'sd1 <<< (osize - 1)) - 64'sd1;
      b.lo = -(64'sd1 <<< (osize - 1));
    end else begin
      b.hi = (64'sd1 <<< osize) - 64'sd1;
      b.lo = 64'sd0;
    end
    return b;
  endfunction

endpackage

// File: rtl/narrow_lane.sv
// Single-lane narrowing datapath, purely combinational. The S1 half shifts and
// derives the rounding increment; the S2 half adds it and saturates.
module narrow_lane
  import narrow_pkg::*;
#(
  parameter int unsigned DSIZE  = 16,
  parameter int unsigned OSIZE  = 8,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned SHW    = $clog2(DSIZE)
) (
  input  logic [DSIZE-1:0] s1_v_i,
  input  logic [SHW-1:0]   s1_shift_i,
  input  logic [1:0]       s1_mode_i,
  output logic [DSIZE-1:0] s1_q_c_o,
  output logic             s1_inc_c_o,
  output logic             s1_sign_c_o,
  input  logic [DSIZE-1:0] s2_q_i,
  input  logic             s2_inc_i,
  input  logic             s2_sign_i,
  output logic [OSIZE-1:0] s2_data_c_o,
  output logic             s2_sat_c_o
);

  localparam int unsigned SW = DSIZE + 1;
  localparam sat_bounds_t BND = sat_bounds(OSIZE, SIGNED);
  localparam logic signed [SW-1:0] HI = SW'(BND.hi);
  localparam logic signed [SW-1:0] LO = SW'(BND.lo);

  logic signed [DSIZE-1:0] v_s;
  logic [DSIZE-1:0]        mask_c;
  logic [DSIZE-1:0]        low_mask_c;
  logic                    d_nz_c;
  logic                    d_msb_c;
  logic                    low_nz_c;
  logic signed [SW-1:0]    sum_c;

  assign v_s = s1_v_i;

  // Shift and classify the dropped bits; a zero shift yields an empty mask, so no rounding.
  always_comb begin : s1_round
    mask_c      = (DSIZE'(1) << s1_shift_i) - DSIZE'(1);
    low_mask_c  = mask_c >> 1;
    d_nz_c      = |(s1_v_i & mask_c);
    d_msb_c     = |(s1_v_i & (mask_c ^ low_mask_c));
    low_nz_c    = |(s1_v_i & low_mask_c);
    s1_sign_c_o = SIGNED && s1_v_i[DSIZE-1];
    if (SIGNED) s1_q_c_o = v_s >>> s1_shift_i;
    else        s1_q_c_o = s1_v_i >> s1_shift_i;
    s1_inc_c_o = 1'b0;
    case (s1_mode_i)
      MODE_HALF_UP: s1_inc_c_o = d_msb_c;
      MODE_CONV:    s1_inc_c_o = d_msb_c & (low_nz_c | s1_q_c_o[0]);
      MODE_CEIL:    s1_inc_c_o = d_nz_c;
      default:      s1_inc_c_o = 1'b0;
    endcase
  end

  // One extra bit of headroom keeps the increment from overflowing before the clamp.
  always_comb begin : s2_saturate
    sum_c       = {s2_sign_i, s2_q_i} + SW'(s2_inc_i);
    s2_data_c_o = sum_c[OSIZE-1:0];
    s2_sat_c_o  = 1'b0;
    if (sum_c > HI) begin
      s2_data_c_o = HI[OSIZE-1:0];
      s2_sat_c_o  = 1'b1;
    end else if (sum_c < LO) begin
      s2_data_c_o = LO[OSIZE-1:0];
      s2_sat_c_o  = 1'b1;
    end
  end

endmodule

// File: rtl/narrow_saturate_pipe.sv
// Multi-lane two-stage shift/round/saturate pipeline with valid/ready on both
// sides and a saturating count of clamped lanes.
module narrow_saturate_pipe
  import narrow_pkg::*;
#(
  parameter int unsigned DSIZE  = 16,
  parameter int unsigned OSIZE  = 8,
  parameter int unsigned LANES  = 4,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned CNTW   = 16,
  parameter int unsigned SHW    = $clog2(DSIZE)
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*DSIZE-1:0] in_data,
  input  logic [SHW-1:0]         in_shift,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OSIZE-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   clr_cnt,
  output logic [CNTW-1:0]        sat_cnt
);

  localparam int unsigned PCW = $clog2(LANES + 1);
  localparam int unsigned CW1 = CNTW + 1;

  logic                   s1_valid_q, s1_valid_d;
  logic [LANES*DSIZE-1:0] s1_q_q, s1_q_d;
  logic [LANES-1:0]       s1_inc_q, s1_inc_d;
  logic [LANES-1:0]       s1_sign_q, s1_sign_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [LANES*OSIZE-1:0] s2_data_q, s2_data_d;
  logic [LANES-1:0]       s2_sat_q, s2_sat_d;
  logic [CNTW-1:0]        sat_cnt_q, sat_cnt_d;

  logic [LANES*DSIZE-1:0] s1_q_c;
  logic [LANES-1:0]       s1_inc_c;
  logic [LANES-1:0]       s1_sign_c;
  logic [LANES*OSIZE-1:0] s2_data_c;
  logic [LANES-1:0]       s2_sat_c;
  logic                   s1_adv_c;
  logic                   s2_adv_c;
  logic [PCW-1:0]         pop_c;
  logic [CW1-1:0]         cnt_sum_c;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    narrow_lane #(
      .DSIZE  (DSIZE),
      .OSIZE  (OSIZE),
      .SIGNED (SIGNED),
      .SHW    (SHW)
    ) u_lane (
      .s1_v_i      (in_data[g*DSIZE +: DSIZE]),
      .s1_shift_i  (in_shift),
      .s1_mode_i   (in_mode),
      .s1_q_c_o    (s1_q_c[g*DSIZE +: DSIZE]),
      .s1_inc_c_o  (s1_inc_c[g]),
      .s1_sign_c_o (s1_sign_c[g]),
      .s2_q_i      (s1_q_q[g*DSIZE +: DSIZE]),
      .s2_inc_i    (s1_inc_q[g]),
      .s2_sign_i   (s1_sign_q[g]),
      .s2_data_c_o (s2_data_c[g*OSIZE +: OSIZE]),
      .s2_sat_c_o  (s2_sat_c[g])
    );
  end

  // Ready ripples back combinationally so a full pipe still moves every cycle.
  assign s2_adv_c = !s2_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign in_ready = s1_adv_c;

  always_comb begin : pipe_next
    s1_valid_d = s1_valid_q;
    s1_q_d     = s1_q_q;
    s1_inc_d   = s1_inc_q;
    s1_sign_d  = s1_sign_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_q_d    = s1_q_c;
        s1_inc_d  = s1_inc_c;
        s1_sign_d = s1_sign_c;
      end
    end
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s2_data_c;
        s2_sat_d  = s2_sat_c;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all ones.
  always_comb begin : cnt_next
    pop_c = '0;
    for (int i = 0; i < LANES; i++) pop_c = pop_c + PCW'(s2_sat_q[i]);
    cnt_sum_c = {1'b0, sat_cnt_q} + CW1'(pop_c);
    sat_cnt_d = sat_cnt_q;
    if (clr_cnt) begin
      sat_cnt_d = '0;
    end else if (s2_valid_q && out_ready) begin
      sat_cnt_d = cnt_sum_c[CNTW] ? '1 : cnt_sum_c[CNTW-1:0];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin : regs
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q_q     <= '0;
      s1_inc_q   <= '0;
      s1_sign_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q_q     <= s1_q_d;
      s1_inc_q   <= s1_inc_d;
      s1_sign_q  <= s1_sign_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_narrow_saturate_pipe.sv
// Directed bench for narrow_saturate_pipe: an unsigned instance (8-bit counter)
// and a signed instance share one stimulus stream.
module tb_narrow_saturate_pipe;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        clr_cnt;
  logic [63:0] in_data;
  logic [3:0]  in_shift;
  logic [1:0]  in_mode;

  logic        u_in_ready, u_out_valid;
  logic [31:0] u_out_data;
  logic [3:0]  u_out_sat;
  logic [7:0]  u_sat_cnt;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_sat;
  logic [15:0] s_sat_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] sd [100];
  int          ssh[100];
  logic [1:0]  smd[100];

  always #5 clock = ~clock;

  narrow_saturate_pipe #(
    .DSIZE(16), .OSIZE(8), .LANES(4), .SIGNED(1'b0), .CNTW(8)
  ) u_uns (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_sat(u_out_sat), .clr_cnt(clr_cnt), .sat_cnt(u_sat_cnt)
  );

  narrow_saturate_pipe #(
    .DSIZE(16), .OSIZE(8), .LANES(4), .SIGNED(1'b1), .CNTW(16)
  ) u_sgn (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_sat(s_out_sat), .clr_cnt(clr_cnt), .sat_cnt(s_sat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one beat with an empty pipe, return when its result is on the output.
  task automatic beat(input logic [63:0] d, input int sh, input logic [1:0] md);
    assert (sh >= 0 && sh < 16) else begin
      miscompares++;
      $error("FAIL shift_range: observed %0d expected below 16", sh);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_shift = 4'(sh);
    in_mode  = md;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  // Arithmetic reference: floor division, remainder against half, then clamp.
  function automatic logic [35:0] model(input logic [63:0] d, input int sh,
                                        input logic [1:0] md, input bit sgn);
    logic [31:0] o;
    logic [3:0]  s;
    logic [15:0] x;
    longint v, q, rem, half, r, y, hi, lo;
    o = '0;
    s = '0;
    hi = sgn ? 64'sd127 : 64'sd255;
    lo = sgn ? -64'sd128 : 64'sd0;
    half = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
    for (int i = 0; i < 4; i++) begin
      x = d[i*16 +: 16];
      if (sgn) v = $signed(x);
      else     v = {48'd0, x};
      q   = v >>> sh;
      rem = v - (q <<< sh);
      case (md)
        2'd0:    r = 64'sd0;
        2'd1:    r = (sh != 0 && rem >= half) ? 64'sd1 : 64'sd0;
        2'd2:    r = (sh != 0 && (rem > half || (rem == half && q[0]))) ? 64'sd1 : 64'sd0;
        default: r = (rem != 0) ? 64'sd1 : 64'sd0;
      endcase
      y = q + r;
      if (y > hi) begin
        y = hi;
        s[i] = 1'b1;
      end else if (y < lo) begin
        y = lo;
        s[i] = 1'b1;
      end
      o[i*8 +: 8] = y[7:0];
    end
    return {s, o};
  endfunction

  initial begin
    logic [35:0] eu, es;
    logic [31:0] got[4];
    int          idx, nrecv;
    bit          acc;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sd[i]  = {$urandom, $urandom};
      ssh[i] = $urandom_range(0, 15);
      smd[i] = 2'($urandom_range(0, 3));
    end

    #12;
    check("rst_out_valid", u_out_valid, 0);
    check("rst_out_data", u_out_data, 0);
    check("rst_out_sat", u_out_sat, 0);
    check("rst_sat_cnt", u_sat_cnt, 0);
    check("rst_in_ready", u_in_ready, 1);
    check("rst_in_ready_s", s_in_ready, 1);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    tick();

    // Unsigned rounding modes, shift 8, plus shift 0 and shift 15 edges.
    beat(64'h00FF_FFFF_0000_12FF, 8, 2'd0);
    check("u_trunc_valid", u_out_valid, 1);
    check("u_trunc_data", u_out_data, 32'h00FF_0012);
    check("u_trunc_sat", u_out_sat, 4'b0000);
    beat(64'h0080_FF80_127F_1280, 8, 2'd1);
    check("u_halfup_data", u_out_data, 32'h01FF_1213);
    check("u_halfup_sat", u_out_sat, 4'b0100);
    beat(64'h137F_1281_1380_1280, 8, 2'd2);
    check("u_conv_data", u_out_data, 32'h1313_1412);
    check("u_conv_sat", u_out_sat, 4'b0000);
    beat(64'h0001_FF01_1200_1201, 8, 2'd3);
    check("u_ceil_data", u_out_data, 32'h01FF_1213);
    check("u_ceil_sat", u_out_sat, 4'b0100);
    beat(64'hFFFF_00FF_0100_00AB, 0, 2'd1);
    check("u_shift0_data", u_out_data, 32'hFFFF_FFAB);
    check("u_shift0_sat", u_out_sat, 4'b1010);
    beat(64'hFFFF_0000_0001_8000, 15, 2'd3);
    check("u_shift15_data", u_out_data, 32'h0200_0101);
    check("u_shift15_sat", u_out_sat, 4'b0000);

    // Signed clamps and negative convergent ties.
    beat(64'h8000_FF80_FF00_7F80, 8, 2'd1);
    check("s_halfup_valid", s_out_valid, 1);
    check("s_halfup_data", s_out_data, 32'h8000_FF7F);
    check("s_halfup_sat", s_out_sat, 4'b0001);
    beat(64'h0800_F800_07F0_8000, 4, 2'd0);
    check("s_trunc4_data", s_out_data, 32'h7F80_7F80);
    check("s_trunc4_sat", s_out_sat, 4'b1001);
    beat(64'h0180_FFC0_FF80_FE80, 8, 2'd2);
    check("s_conv_data", s_out_data, 32'h0200_00FE);
    check("s_conv_sat", s_out_sat, 4'b0000);
    tick();

    // Full-rate stream: each result appears exactly two cycles after its beat.
    for (int c = 0; c < 102; c++) begin
      if (c >= 2) begin
        eu = model(sd[c-2], ssh[c-2], smd[c-2], 1'b0);
        es = model(sd[c-2], ssh[c-2], smd[c-2], 1'b1);
        check($sformatf("stream%0d_u_valid", c - 2), u_out_valid, 1);
        check($sformatf("stream%0d_u_data", c - 2), u_out_data, eu[31:0]);
        check($sformatf("stream%0d_u_sat", c - 2), u_out_sat, eu[35:32]);
        check($sformatf("stream%0d_s_valid", c - 2), s_out_valid, 1);
        check($sformatf("stream%0d_s_data", c - 2), s_out_data, es[31:0]);
        check($sformatf("stream%0d_s_sat", c - 2), s_out_sat, es[35:32]);
      end else begin
        check($sformatf("stream_pre%0d_valid", c), u_out_valid, 0);
      end
      if (c < 100) begin
        in_valid = 1'b1;
        in_data  = sd[c];
        in_shift = 4'(ssh[c]);
        in_mode  = smd[c];
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;

    // Backpressure: 5 stalled cycles while 4 beats are offered.
    idx = 0;
    nrecv = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c >= 5);
      in_valid  = (idx < 4);
      in_data   = {4{16'h0A00 + 16'(idx) * 16'h0100}};
      in_shift  = 4'd8;
      in_mode   = 2'd0;
      #1;
      acc = in_valid && u_in_ready;
      if (c >= 2 && c < 5) begin
        check($sformatf("bp_stall%0d_valid", c), u_out_valid, 1);
        check($sformatf("bp_stall%0d_data", c), u_out_data, {4{8'h0A}});
      end
      if (u_out_valid && out_ready) begin
        if (nrecv < 4) got[nrecv] = u_out_data;
        nrecv++;
      end
      tick();
      if (acc) idx++;
      if (c == 4) begin
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_in_ready_low", u_in_ready, 0);
      end
    end
    in_valid = 1'b0;
    check("bp_received", 64'(nrecv), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < nrecv) check($sformatf("bp_order%0d", k), got[k], {4{8'(8'h0A + k)}});
    end

    // Counter: popcount accumulation, saturation at 255, clear priority.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("cnt_clear", u_sat_cnt, 0);
    for (int k = 0; k < 3; k++) beat(64'h0000_0000_FFFF_FFFF, 0, 2'd0);
    tick();
    check("cnt_popcount", u_sat_cnt, 8'd6);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0000_FFFF;
    in_shift = 4'd0;
    in_mode  = 2'd0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 200) check("cnt_mid", u_sat_cnt, 8'd198);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("cnt_saturated", u_sat_cnt, 8'hFF);
    beat(64'h0000_0000_0000_FFFF, 0, 2'd0);
    check("cnt_clr_pre_sat", u_out_sat, 4'b0001);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("cnt_clr_wins", u_sat_cnt, 0);

    // Reset with both stages full.
    beat(64'hFFFF_FFFF_FFFF_FFFF, 0, 2'd0);
    tick();
    check("cnt_four_lanes", u_sat_cnt, 8'd4);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("rst2_pre_valid", u_out_valid, 1);
    check("rst2_pre_in_ready", u_in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_out_valid", u_out_valid, 0);
    check("rst2_out_data", u_out_data, 0);
    check("rst2_out_sat", u_out_sat, 0);
    check("rst2_sat_cnt", u_sat_cnt, 0);
    check("rst2_sat_cnt_s", s_sat_cnt, 0);
    check("rst2_in_ready", u_in_ready, 1);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rst2_no_stale%0d_u", k), u_out_valid, 0);
      check($sformatf("rst2_no_stale%0d_s", k), s_out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
